// File: rtl/vdp_pkg.sv
// vdp_pkg: shared constants and types for the VDP CPU port controller.
// Access codes, port numbers, FSM states and the VRAM access bundle.
package vdp_pkg;

  localparam int ADDR_W = 14;

  localparam logic [1:0] CODE_VRD  = 2'd0;
  localparam logic [1:0] CODE_VWR  = 2'd1;
  localparam logic [1:0] CODE_REG  = 2'd2;
  localparam logic [1:0] CODE_CRAM = 2'd3;

  localparam logic [7:0] PORT_DATA = 8'hBE;
  localparam logic [7:0] PORT_CTRL = 8'hBF;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              we;
  } vacc_t;

endpackage

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: Z80-side VDP port sequencer and VRAM req/ack arbiter.
// Define VDP_CRAM_EN to route code-3 data writes to CRAM.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int ACK_TIMEOUT = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_stb,
  input  logic              rd_stb,
  input  logic              port_ctrl,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic [7:0]        status_in,
  output logic              status_clr,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  output logic              vram_req,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  output logic              reg_we,
  output logic [3:0]        reg_addr,
  output logic [7:0]        reg_data,
  output logic              cram_we,
  output logic [4:0]        cram_addr,
  output logic [7:0]        cram_data,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LIM = TW'(ACK_TIMEOUT - 1);

  logic              first;
  logic [7:0]        latch;
  logic [1:0]        code;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rbuf;

  state_t state, state_nx;
  vacc_t  cur, pend, acc;
  logic   pend_v;
  logic [TW-1:0] wait_cnt;

  logic wr_ctrl, wr_data, rd_ctrl, rd_data, ctl2;
  logic cram_hit, acc_new;
  logic load_cur, promote, load_pend, drop;
  logic rd_done, tmo;
  logic [ADDR_W-1:0] new_addr;

  // a write strobe overrides a simultaneous read strobe
  assign wr_ctrl  = wr_stb & port_ctrl;
  assign wr_data  = wr_stb & ~port_ctrl;
  assign rd_ctrl  = rd_stb & ~wr_stb & port_ctrl;
  assign rd_data  = rd_stb & ~wr_stb & ~port_ctrl;
  assign ctl2     = wr_ctrl & first;
  assign new_addr = {din[5:0], latch};

`ifdef VDP_CRAM_EN
  assign cram_hit = wr_data & (code == CODE_CRAM);
`else
  assign cram_hit = 1'b0;
  logic unused_code;
  assign unused_code = ^code;
`endif

  assign acc_new = (ctl2 & (din[7:6] == CODE_VRD))
                 | (wr_data & ~cram_hit)
                 | rd_data;
  assign acc.addr  = ctl2 ? new_addr : addr;
  assign acc.wdata = din;
  assign acc.we    = wr_data;

  assign dout       = port_ctrl ? status_in : rbuf;
  assign vram_req   = (state == REQ);
  assign busy       = (state == REQ);
  assign vram_addr  = cur.addr;
  assign vram_wdata = cur.wdata;
  assign vram_we    = cur.we;

  assign rd_done = vram_req & vram_ack & ~cur.we;
  assign tmo     = vram_req & ~vram_ack & (wait_cnt == LIM);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state plus slot steering: load, promote, queue or drop
  always_comb begin
    state_nx  = state;
    load_cur  = 1'b0;
    promote   = 1'b0;
    load_pend = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc_new) begin
          state_nx = REQ;
          load_cur = 1'b1;
        end
      end
      REQ: begin
        if (vram_ack) begin
          if (pend_v) begin
            promote   = 1'b1;
            load_pend = acc_new;
          end else if (acc_new) begin
            load_cur = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (acc_new) begin
          if (pend_v) drop = 1'b1;
          else        load_pend = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // active request, pending slot and ack-wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (load_cur)     cur <= acc;
      else if (promote) cur <= pend;
      if (load_pend)    pend <= acc;
      if (promote)        pend_v <= load_pend;
      else if (load_pend) pend_v <= 1'b1;
      if (!vram_req || vram_ack || load_cur) wait_cnt <= '0;
      else if (wait_cnt != LIM)              wait_cnt <= wait_cnt + 1'b1;
      if (drop || tmo) err <= 1'b1;
    end
  end

  // control-port sequencing, address counter and read buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first <= 1'b0;
      latch <= '0;
      code  <= CODE_VRD;
      addr  <= '0;
      rbuf  <= '0;
    end else begin
      if (wr_ctrl && !first) begin
        first     <= 1'b1;
        latch     <= din;
        addr[7:0] <= din;
      end else if (ctl2) begin
        first <= 1'b0;
        code  <= din[7:6];
        if (din[7:6] == CODE_VRD) addr <= new_addr + 1'b1;
        else                      addr <= new_addr;
      end else if (wr_data || rd_data) begin
        first <= 1'b0;
        addr  <= addr + 1'b1;
      end else if (rd_ctrl) begin
        first <= 1'b0;
      end
      if (wr_data)      rbuf <= din;
      else if (rd_done) rbuf <= vram_rdata;
    end
  end

  // one-cycle strobes for register, CRAM and status side effects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
      status_clr <= 1'b0;
    end else begin
      status_clr <= rd_ctrl;
      reg_we     <= ctl2 & (din[7:6] == CODE_REG);
      if (ctl2 && din[7:6] == CODE_REG) begin
        reg_addr <= din[3:0];
        reg_data <= latch;
      end
    end
  end

`ifdef VDP_CRAM_EN
  // CRAM write strobe, indexed by the low address bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cram_we   <= 1'b0;
      cram_addr <= '0;
      cram_data <= '0;
    end else begin
      cram_we <= cram_hit;
      if (cram_hit) begin
        cram_addr <= addr[4:0];
        cram_data <= din;
      end
    end
  end
`else
  assign cram_we   = 1'b0;
  assign cram_addr = '0;
  assign cram_data = '0;
`endif

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// tb_vdp_port_ctrl: directed bench for vdp_port_ctrl.
// Includes a VRAM responder model with switchable ack.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_stb = 1'b0;
  logic        rd_stb = 1'b0;
  logic        port_ctrl = 1'b0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic [7:0]  status_in = 8'hA5;
  logic        status_clr;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_req;
  logic        vram_ack;
  logic [7:0]  vram_rdata;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        cram_we;
  logic [4:0]  cram_addr;
  logic [7:0]  cram_data;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:16383];
  logic [13:0] wa [$];
  logic [7:0]  wd [$];
  logic        ack_en = 1'b1;
  int          ack_lat = 1;
  logic [7:0]  obs;

  vdp_port_ctrl #(.ACK_TIMEOUT(6)) dut (
    .clk(clk), .reset(reset),
    .wr_stb(wr_stb), .rd_stb(rd_stb),
    .port_ctrl(port_ctrl), .din(din), .dout(dout),
    .status_in(status_in), .status_clr(status_clr),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_req(vram_req),
    .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_data(reg_data), .cram_we(cram_we),
    .cram_addr(cram_addr), .cram_data(cram_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // VRAM responder: acks after ack_lat waiting cycles
  initial begin : responder
    int lat;
    lat = 0;
    vram_ack = 1'b0;
    vram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      vram_ack = 1'b0;
      if (vram_req && ack_en && !reset) begin
        if (lat >= ack_lat) begin
          vram_ack = 1'b1;
          lat = 0;
          if (vram_we) begin
            mem[vram_addr] = vram_wdata;
            wa.push_back(vram_addr);
            wd.push_back(vram_wdata);
          end else begin
            vram_rdata = mem[vram_addr];
          end
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic p, input logic [7:0] d);
    wr_stb = 1'b1;
    port_ctrl = p;
    din = d;
    cyc();
    wr_stb = 1'b0;
  endtask

  task automatic rd(input logic p, output logic [7:0] q);
    rd_stb = 1'b1;
    port_ctrl = p;
    #1;
    q = dout;
    cyc();
    rd_stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h1234] = 8'h5A;
    mem[14'h1235] = 8'hC3;

    // reset state
    repeat (3) cyc();
    check("rst_req", {31'd0, vram_req}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_reg_we", {31'd0, reg_we}, 0);
    check("rst_reg_addr", {28'd0, reg_addr}, 0);
    check("rst_status_clr", {31'd0, status_clr}, 0);
    check("rst_vram_addr", {18'd0, vram_addr}, 0);
    check("rst_rbuf", {24'd0, dout}, 0);
    reset = 1'b0;
    cyc();

    // register write: 0x34, 0x81
    wr(1'b1, 8'h34);
    wr(1'b1, 8'h81);
    check("reg_we", {31'd0, reg_we}, 1);
    check("reg_addr", {28'd0, reg_addr}, 1);
    check("reg_data", {24'd0, reg_data}, 32'h34);
    check("reg_noreq", {31'd0, vram_req}, 0);
    cyc();
    check("reg_we_pulse", {31'd0, reg_we}, 0);
    check("reg_noreq2", {31'd0, vram_req}, 0);

    // VRAM writes 0xAA@0, 0xBB@1
    wr(1'b1, 8'h00);
    wr(1'b1, 8'h40);
    wr(1'b0, 8'hAA);
    check("w1_req", {31'd0, vram_req}, 1);
    check("w1_addr", {18'd0, vram_addr}, 0);
    check("w1_we", {31'd0, vram_we}, 1);
    wr(1'b0, 8'hBB);
    wait_idle("w_idle");
    check("w_count", wa.size(), 2);
    check("w0_addr", {18'd0, wa[0]}, 0);
    check("w0_data", {24'd0, wd[0]}, 32'hAA);
    check("w1_log_addr", {18'd0, wa[1]}, 1);
    check("w1_log_data", {24'd0, wd[1]}, 32'hBB);
    wr(1'b0, 8'hCC);
    check("w2_addr", {18'd0, vram_addr}, 2);
    wait_idle("w2_idle");

    // read-ahead from 0x1234
    wr(1'b1, 8'h34);
    wr(1'b1, 8'h12);
    check("pf_req", {31'd0, vram_req}, 1);
    check("pf_addr", {18'd0, vram_addr}, 32'h1234);
    check("pf_we", {31'd0, vram_we}, 0);
    wait_idle("pf_idle");
    repeat (4) cyc();
    rd(1'b0, obs);
    check("rd1_data", {24'd0, obs}, 32'h5A);
    check("rd1_addr", {18'd0, vram_addr}, 32'h1235);
    wait_idle("rd1_idle");
    repeat (4) cyc();
    rd(1'b0, obs);
    check("rd2_data", {24'd0, obs}, 32'hC3);
    wait_idle("rd2_idle");

    // address wrap at 0x3FFF
    wr(1'b1, 8'hFF);
    wr(1'b1, 8'h7F);
    wr(1'b0, 8'h11);
    check("wrap_w_addr", {18'd0, vram_addr}, 32'h3FFF);
    wait_idle("wrap_idle1");
    wr(1'b0, 8'h22);
    check("wrap_next", {18'd0, vram_addr}, 0);
    wait_idle("wrap_idle2");

    // queue one, drop one, with ack held low
    wr(1'b1, 8'h00);
    wr(1'b1, 8'h41);
    ack_en = 1'b0;
    wa.delete();
    wd.delete();
    wr(1'b0, 8'h01);
    check("q_err0", {31'd0, err}, 0);
    wr(1'b0, 8'h02);
    check("q_err1", {31'd0, err}, 0);
    wr(1'b0, 8'h03);
    check("drop_err", {31'd0, err}, 1);
    check("q_cur_addr", {18'd0, vram_addr}, 32'h100);
    check("q_cur_data", {24'd0, vram_wdata}, 32'h01);
    check("q_busy", {31'd0, busy}, 1);
    ack_en = 1'b1;
    wait_idle("q_idle");
    check("q_count", wa.size(), 2);
    check("q0_addr", {18'd0, wa[0]}, 32'h100);
    check("q0_data", {24'd0, wd[0]}, 32'h01);
    check("q1_addr", {18'd0, wa[1]}, 32'h101);
    check("q1_data", {24'd0, wd[1]}, 32'h02);

    // control read resets the byte sequencer
    wr(1'b1, 8'h10);
    rd(1'b1, obs);
    check("st_dout", {24'd0, obs}, 32'hA5);
    check("st_clr", {31'd0, status_clr}, 1);
    cyc();
    check("st_clr_pulse", {31'd0, status_clr}, 0);
    wr(1'b1, 8'h00);
    wr(1'b1, 8'h40);
    check("st_noreq", {31'd0, vram_req}, 0);
    wr(1'b0, 8'h77);
    check("st_addr", {18'd0, vram_addr}, 0);
    check("st_we", {31'd0, vram_we}, 1);
    wait_idle("st_idle");

    // simultaneous strobes: write wins
    wr_stb = 1'b1;
    rd_stb = 1'b1;
    port_ctrl = 1'b1;
    din = 8'h20;
    cyc();
    wr_stb = 1'b0;
    rd_stb = 1'b0;
    check("sim_noclr", {31'd0, status_clr}, 0);
    wr(1'b1, 8'h40);
    wr(1'b0, 8'h99);
    check("sim_addr", {18'd0, vram_addr}, 32'h20);
    wait_idle("sim_idle");

    // async reset mid-request
    ack_en = 1'b0;
    wr(1'b0, 8'h55);
    check("ar_req", {31'd0, vram_req}, 1);
    reset = 1'b1;
    #1;
    check("ar_req_drop", {31'd0, vram_req}, 0);
    check("ar_err_clr", {31'd0, err}, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // ack timeout after six waiting cycles
    wr(1'b0, 8'h66);
    repeat (5) cyc();
    check("to_err_early", {31'd0, err}, 0);
    cyc();
    check("to_err", {31'd0, err}, 1);
    check("to_req_held", {31'd0, vram_req}, 1);
    ack_en = 1'b1;
    wait_idle("to_idle");
    check("to_err_sticky", {31'd0, err}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_port_ctrl.md
# vdp_port_ctrl

CPU-side port controller for the SMS VDP, sitting between the Z80 I/O decode and the VDP VRAM, CRAM and register file. It sequences the two-byte control-port protocol, owns the 14-bit VRAM address counter and the one-byte read-ahead buffer, and issues register and CRAM writes. It arbitrates CPU-originated VRAM reads and writes onto a single req/ack VRAM port. It replaces the ad hoc control-port latch and address logic in the top level.

## Interface
Parameters:
- ACK_TIMEOUT, 6: max cycles `vram_req` may wait for `vram_ack` before `err` is set.

Ports:
- clk  in  1  system clock (cpuClock domain).
- reset  in  1  asynchronous, active-high.
- wr_stb  in  1  one-cycle pulse per CPU I/O write to VDP ports.
- rd_stb  in  1  one-cycle pulse marking the end of a CPU I/O read of VDP ports.
- port_ctrl  in  1  1 = control port (0xBF), 0 = data port (0xBE); sampled with the strobes.
- din  in  8  CPU write data.
- dout  out  8  CPU read data: status when `port_ctrl`, else the read buffer; combinational.
- status_in  in  8  status byte from the video core.
- status_clr  out  1  one-cycle pulse after a control-port read.
- vram_addr  out  14  VRAM address for the current request.
- vram_wdata  out  8  VRAM write data.
- vram_we  out  1  request is a write.
- vram_req  out  1  request valid; held until ack.
- vram_ack  in  1  one-cycle completion; read data valid this cycle.
- vram_rdata  in  8  VRAM read data.
- reg_we  out  1  one-cycle register write strobe.
- reg_addr  out  4  register index.
- reg_data  out  8  register value.
- cram_we  out  1  one-cycle CRAM write strobe.
- cram_addr  out  5  CRAM index.
- cram_data  out  8  CRAM data.
- busy  out  1  a VRAM request is pending or outstanding.
- err  out  1  sticky: ack timeout or dropped access; cleared only by reset.

## Operation
- Internal state:
  - `first` flag: 0 = expecting the first control byte.
  - `latch[7:0]`: first control byte.
  - `code[1:0]`: access code.
  - `addr[13:0]`: VRAM address counter.
  - `rbuf[7:0]`: read-ahead buffer.
- Control write, `first`=0: latch <= din, first <= 1, addr[7:0] <= din.
- Control write, `first`=1: first <= 0, code <= din[7:6], then by code:
  - code 0: addr <= {din[5:0], latch}; issue a VRAM read at the new addr; on ack rbuf <= vram_rdata and addr++.
  - code 1: addr <= {din[5:0], latch}; no VRAM access.
  - code 2: reg_we pulse, reg_addr = din[3:0], reg_data = latch; addr and code still update as in code 1.
  - code 3: addr <= {din[5:0], latch}.
- Data write:
  - code 3: cram_we, cram_addr = addr[4:0].
  - Otherwise: VRAM write of din at addr.
  - In both cases rbuf <= din, addr++ (wraps 0x3FFF -> 0x0000), first <= 0.
- Data read: dout = rbuf during the read. On rd_stb, issue a VRAM read at addr, then on ack rbuf <= data and addr++; first <= 0.
- Control read: dout = status_in; on rd_stb, status_clr pulse and first <= 0.
- FSM states:
  - IDLE -> REQ on any VRAM access.
  - REQ -> IDLE on ack when nothing is pending.
  - REQ -> REQ on ack when a pending access exists; the pending entry is promoted.
- Pending queue: one entry. A VRAM access arriving while busy goes into the pending slot. If the slot is full, the access is dropped and err <= 1.
- Address used by a queued access is the counter value at queue time; addr increments at queue time, not at ack.

## Timing
- Reset values: first=0, code=0, addr=0, rbuf=0, latch=0; all strobes, vram_req, busy and err are 0; vram_addr=0, vram_wdata=0, reg_*=0, cram_*=0.
- vram_req rises the cycle after the qualifying strobe and is held until the ack cycle inclusive; it falls the cycle after ack unless a pending access is promoted.
- reg_we and cram_we go high the cycle after the strobe, for exactly one cycle.
- rbuf updates on the ack edge; a CPU read ≥7 cycles after the previous read strobe sees fresh data, provided ack latency is ≤5.
- Ack timeout: ACK_TIMEOUT cycles in REQ without ack -> err <= 1. The request stays asserted.
- Simultaneous wr_stb and rd_stb: the write wins and the read is ignored.
- Asynchronous reset mid-request drops vram_req immediately; any ack after reset is ignored.

## Configuration
- `VDP_CRAM_EN` defined: code 3 data writes go to CRAM as described.
- `VDP_CRAM_EN` undefined: code 3 data writes behave as VRAM writes. cram_we, cram_addr and cram_data are tied to 0.

## Structure
- Package `vdp_pkg`:
  - code constants CODE_VRD=0, CODE_VWR=1, CODE_REG=2, CODE_CRAM=3;
  - FSM state enum {IDLE, REQ};
  - port constants 8'hBE and 8'hBF;
  - address width 14.
- No sub-module: the single pending slot and FSM are small enough to live inline.

## Test plan
- Control writes 0x34, 0x81 -> reg_we one cycle later, reg_addr=1, reg_data=0x34; no vram_req.
- Control writes 0x00, 0x40, then data writes 0xAA, 0xBB -> VRAM writes 0xAA@0x0000 and 0xBB@0x0001; addr=0x0002.
- Preload VRAM 0x1234=0x5A, 0x1235=0xC3; control writes 0x34, 0x12 -> prefetch 0x5A into rbuf. First data read returns 0x5A; second data read returns 0xC3.
- addr=0x3FFF under code 1, data write -> write @0x3FFF, then addr=0x0000.
- Hold vram_ack low and issue three data writes -> the second is queued, the third is dropped and err=1; after ack, the queued write issues.
- Single control write 0x10, then control read -> status_clr pulse and first=0. The next control writes 0x00, 0x40 set addr=0x0000.
